// File: rtl/fios_step_sequencer_if.sv
// Step bus between fios_step_sequencer (master) and the two-stage step_add datapath (slave).
// The product pairs are (a_0,a_1), (b_0,b_1) and (c_0,c_1).
interface fios_step_sequencer_if #(parameter int RADIX = 32);
    logic [RADIX-1:0] a_0, a_1, b_0, b_1, c_0, c_1;
    logic [RADIX-1:0] d;
    logic             d_last;
    logic [RADIX+1:0] carry_in;
    logic [RADIX-1:0] step_sum;
    logic [RADIX+1:0] step_carry;

    modport master (
        output a_0, a_1, b_0, b_1, c_0, c_1, d, d_last, carry_in,
        input  step_sum, step_carry
    );
    modport slave (
        input  a_0, a_1, b_0, b_1, c_0, c_1, d, d_last, carry_in,
        output step_sum, step_carry
    );
endinterface

// File: rtl/fios_step_sequencer.sv
// One outer-loop iteration of the unified FIOS inner j-loop: reads words, issues one step per
// cycle to step_add, closes the carry loop and writes the running sum back one word down.
module fios_step_sequencer #(
    parameter int RADIX     = 32,
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    // start is sampled only while idle; busy covers the cycle after acceptance through done,
    // and done is a single-cycle pulse. There is no back-pressure on either side.
    input  logic                  start,
    input  logic [RADIX-1:0]      ob0_i,
    input  logic [RADIX-1:0]      ob1_i,
    input  logic [RADIX-1:0]      mm,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     op_rd_addr,
    input  logic [RADIX-1:0]      oa0_rd,
    input  logic [RADIX-1:0]      oa1_rd,
    input  logic [RADIX-1:0]      m_rd,
    output logic [ADDR_W-1:0]     t_rd_addr,
    input  logic [RADIX-1:0]      t_rd,
    fios_step_sequencer_if.master step,
    output logic                  t_wr_en,
    output logic [ADDR_W-1:0]     t_wr_addr,
    output logic [RADIX-1:0]      t_wr_data,
    output logic [1:0]            t_top,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINAL} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rd_idx, rd_idx_nxt;
    logic                iss_v, d_v, w_v;
    logic [ADDR_W-1:0]   iss_idx, d_idx, w_idx;
    logic [RADIX-1:0]    carry_lo;
    logic                latch_carry;
    logic                rd_v, wb_step, fin;

    // Step pipeline: read request -> issue (operands) -> d/carry_in -> writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_idx   <= '0;
            iss_v    <= 1'b0;
            iss_idx  <= '0;
            d_v      <= 1'b0;
            d_idx    <= '0;
            w_v      <= 1'b0;
            w_idx    <= '0;
            carry_lo <= '0;
            t_top    <= '0;
        end else begin
            state   <= state_nxt;
            rd_idx  <= rd_idx_nxt;
            iss_v   <= rd_v;
            iss_idx <= rd_idx;
            d_v     <= iss_v;
            d_idx   <= iss_idx;
            w_v     <= d_v;
            w_idx   <= d_idx;
            if (latch_carry) begin
                carry_lo <= step.step_carry[RADIX-1:0];
                t_top    <= step.step_carry[RADIX+1:RADIX];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_idx_nxt  = rd_idx;
        latch_carry = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_RUN;
                    rd_idx_nxt = '0;
                end
            end
            S_RUN: begin
                if (rd_idx == LAST) begin
                    state_nxt  = S_DRAIN;
                    rd_idx_nxt = '0;
                end else begin
                    rd_idx_nxt = rd_idx + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last step's carry is on step_carry in its writeback cycle.
                if (w_v && (w_idx == LAST)) begin
                    state_nxt   = S_FINAL;
                    latch_carry = 1'b1;
                end
            end
            S_FINAL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd_v       = (state == S_RUN);
    assign fin        = (state == S_FINAL);
    assign wb_step    = w_v && (w_idx != '0);
    assign busy       = (state != S_IDLE);
    assign done       = fin;
    assign dbg_state  = state;
    assign op_rd_addr = rd_idx;
    assign t_rd_addr  = iss_idx;

    // Idle steps see all-zero inputs so the datapath produces zero sum and carry.
    assign step.a_0      = iss_v ? oa0_rd : '0;
    assign step.a_1      = iss_v ? ob0_i  : '0;
    assign step.b_0      = iss_v ? oa1_rd : '0;
    assign step.b_1      = iss_v ? ob1_i  : '0;
    assign step.c_0      = iss_v ? m_rd   : '0;
    assign step.c_1      = iss_v ? mm     : '0;
    assign step.d        = d_v ? t_rd : '0;
    assign step.d_last   = d_v && (d_idx == LAST);
    assign step.carry_in = (d_v && (d_idx != '0)) ? step.step_carry : '0;

    // Step 0's sum is dropped; step j>=1 lands one word down, the final carry fills the top word.
    assign t_wr_en   = wb_step || fin;
    assign t_wr_addr = fin ? LAST : (wb_step ? w_idx - 1'b1 : '0);
    assign t_wr_data = fin ? carry_lo : (wb_step ? step.step_sum : '0);
endmodule

// File: tb/tb_fios_step_sequencer.sv
// Bench for fios_step_sequencer: an 8-bit/2-word instance for the hand-worked vectors and a
// 32-bit/8-word instance checked against a software FIOS model through a write scoreboard.
module tb_fios_step_sequencer;
    localparam int RS = 8;
    localparam int NS = 2;
    localparam int AS = 1;
    localparam int RB = 32;
    localparam int NB = 8;
    localparam int AB = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- small instance ----------------
    logic          s_start, s_busy, s_done, s_wr_en, s_ld_en;
    logic [RS-1:0] s_ob0, s_ob1, s_mm, s_oa0_rd, s_oa1_rd, s_m_rd, s_t_rd, s_wr_data, s_ld_data;
    logic [AS-1:0] s_op_addr, s_t_rd_addr, s_wr_addr, s_ld_addr;
    logic [1:0]    s_top, s_dbg;
    logic [RS-1:0] s_oa0[NS], s_oa1[NS], s_m[NS], s_t[NS];
    logic [127:0]  s_prod, s_tot;
    logic [15:0]   s_exp_q[$];

    fios_step_sequencer_if #(.RADIX(RS)) s_if();

    fios_step_sequencer #(.RADIX(RS), .NUM_WORDS(NS), .ADDR_W(AS)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .ob0_i(s_ob0), .ob1_i(s_ob1), .mm(s_mm),
        .busy(s_busy), .done(s_done), .op_rd_addr(s_op_addr), .oa0_rd(s_oa0_rd),
        .oa1_rd(s_oa1_rd), .m_rd(s_m_rd), .t_rd_addr(s_t_rd_addr), .t_rd(s_t_rd),
        .step(s_if), .t_wr_en(s_wr_en), .t_wr_addr(s_wr_addr), .t_wr_data(s_wr_data),
        .t_top(s_top), .dbg_state(s_dbg)
    );

    assign s_tot = s_prod + 128'(s_if.d) + 128'(s_if.carry_in);

    always @(posedge clk) begin
        if (rst) begin
            s_prod <= '0;
            s_if.step_sum <= '0;
            s_if.step_carry <= '0;
        end else begin
            s_prod <= 128'(s_if.a_0) * 128'(s_if.a_1) + 128'(s_if.b_0) * 128'(s_if.b_1)
                    + 128'(s_if.c_0) * 128'(s_if.c_1);
            s_if.step_sum <= s_tot[RS-1:0];
            s_if.step_carry <= s_tot[2*RS+1:RS];
        end
        s_oa0_rd <= s_oa0[s_op_addr];
        s_oa1_rd <= s_oa1[s_op_addr];
        s_m_rd   <= s_m[s_op_addr];
        s_t_rd   <= s_t[s_t_rd_addr];
        if (s_wr_en) s_t[s_wr_addr] <= s_wr_data;
        else if (s_ld_en) s_t[s_ld_addr] <= s_ld_data;
    end

    // ---------------- big instance ----------------
    logic          b_start, b_busy, b_done, b_wr_en, b_ld_en;
    logic [RB-1:0] b_ob0, b_ob1, b_mm, b_oa0_rd, b_oa1_rd, b_m_rd, b_t_rd, b_wr_data, b_ld_data;
    logic [AB-1:0] b_op_addr, b_t_rd_addr, b_wr_addr, b_ld_addr;
    logic [1:0]    b_top, b_dbg, b_top_exp;
    logic [RB-1:0] b_oa0[NB], b_oa1[NB], b_m[NB], b_t[NB];
    logic [127:0]  b_prod, b_tot;
    logic [39:0]   b_exp_q[$];

    fios_step_sequencer_if #(.RADIX(RB)) b_if();

    fios_step_sequencer #(.RADIX(RB), .NUM_WORDS(NB), .ADDR_W(AB)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .ob0_i(b_ob0), .ob1_i(b_ob1), .mm(b_mm),
        .busy(b_busy), .done(b_done), .op_rd_addr(b_op_addr), .oa0_rd(b_oa0_rd),
        .oa1_rd(b_oa1_rd), .m_rd(b_m_rd), .t_rd_addr(b_t_rd_addr), .t_rd(b_t_rd),
        .step(b_if), .t_wr_en(b_wr_en), .t_wr_addr(b_wr_addr), .t_wr_data(b_wr_data),
        .t_top(b_top), .dbg_state(b_dbg)
    );

    assign b_tot = b_prod + 128'(b_if.d) + 128'(b_if.carry_in);

    always @(posedge clk) begin
        if (rst) begin
            b_prod <= '0;
            b_if.step_sum <= '0;
            b_if.step_carry <= '0;
        end else begin
            b_prod <= 128'(b_if.a_0) * 128'(b_if.a_1) + 128'(b_if.b_0) * 128'(b_if.b_1)
                    + 128'(b_if.c_0) * 128'(b_if.c_1);
            b_if.step_sum <= b_tot[RB-1:0];
            b_if.step_carry <= b_tot[2*RB+1:RB];
        end
        b_oa0_rd <= b_oa0[b_op_addr];
        b_oa1_rd <= b_oa1[b_op_addr];
        b_m_rd   <= b_m[b_op_addr];
        b_t_rd   <= b_t[b_t_rd_addr];
        if (b_wr_en) b_t[b_wr_addr] <= b_wr_data;
        else if (b_ld_en) b_t[b_ld_addr] <= b_ld_data;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_b_busy"}, b_busy, 0);
        chk({tag, "_b_done"}, b_done, 0);
        chk({tag, "_b_wr_en"}, b_wr_en, 0);
        chk({tag, "_b_d_last"}, b_if.d_last, 0);
        chk({tag, "_b_op_addr"}, b_op_addr, 0);
        chk({tag, "_b_t_rd_addr"}, b_t_rd_addr, 0);
        chk({tag, "_b_wr_addr"}, b_wr_addr, 0);
        chk({tag, "_b_wr_data"}, b_wr_data, 0);
        chk({tag, "_b_a_0"}, b_if.a_0, 0);
        chk({tag, "_b_c_1"}, b_if.c_1, 0);
        chk({tag, "_b_d"}, b_if.d, 0);
        chk({tag, "_b_carry_in"}, b_if.carry_in, 0);
        chk({tag, "_b_t_top"}, b_top, 0);
        chk({tag, "_b_state"}, b_dbg, 0);
        chk({tag, "_s_busy"}, s_busy, 0);
        chk({tag, "_s_wr_en"}, s_wr_en, 0);
    endtask

    task automatic s_load(input int a, input logic [RS-1:0] v);
        s_ld_en = 1'b1;
        s_ld_addr = AS'(a);
        s_ld_data = v;
        @(negedge clk);
        s_ld_en = 1'b0;
    endtask

    task automatic b_load(input int a, input logic [RB-1:0] v);
        b_ld_en = 1'b1;
        b_ld_addr = AB'(a);
        b_ld_data = v;
        @(negedge clk);
        b_ld_en = 1'b0;
    endtask

    // Golden FIOS inner loop over the bench's own RAM contents; pushes expected writes in order.
    task automatic b_push();
        logic [127:0] p;
        logic [33:0]  c;
        c = '0;
        for (int j = 0; j < NB; j++) begin
            p = 128'(b_oa0[j]) * 128'(b_ob0) + 128'(b_oa1[j]) * 128'(b_ob1)
              + 128'(b_m[j]) * 128'(b_mm) + 128'(b_t[j]) + 128'(c);
            if (j > 0) b_exp_q.push_back({8'(j - 1), p[31:0]});
            c = p[65:32];
        end
        b_exp_q.push_back({8'(NB - 1), c[31:0]});
        b_top_exp = c[33:32];
    endtask

    task automatic s_iter(input logic [15:0] w0, input logic [15:0] w1, input logic [1:0] top,
                          input logic [9:0] cin1);
        s_exp_q.push_back(w0);
        s_exp_q.push_back(w1);
        s_start = 1'b1;
        for (int cyc = 1; cyc <= NS + 4; cyc++) begin
            @(negedge clk);
            s_start = 1'b0;
            chk("s_busy", s_busy, 1);
            chk("s_done", s_done, cyc == NS + 4);
            chk("s_wr_en", s_wr_en, cyc >= 5);
            if (cyc == 3) chk("s_cin_j0", s_if.carry_in, 0);
            if (cyc == 4) begin
                chk("s_cin_j1", s_if.carry_in, cin1);
                chk("s_d_last", s_if.d_last, 1);
            end
            if (s_wr_en) begin
                chk("s_sb_nonempty", s_exp_q.size() != 0, 1);
                if (s_exp_q.size() != 0)
                    chk("s_wr", {8'(s_wr_addr), s_wr_data}, s_exp_q.pop_front());
            end
            if (cyc == NS + 4) chk("s_t_top", s_top, top);
        end
        @(negedge clk);
        chk("s_busy_after", s_busy, 0);
        chk("s_sb_empty", s_exp_q.size(), 0);
    endtask

    task automatic b_iter(input bit keep_start, input int abort_at);
        b_push();
        b_start = 1'b1;
        for (int cyc = 1; cyc <= NB + 4; cyc++) begin
            @(negedge clk);
            if (!keep_start) b_start = 1'b0;
            chk("b_busy", b_busy, 1);
            chk("b_done", b_done, cyc == NB + 4);
            chk("b_d_last", b_if.d_last, cyc == NB + 2);
            chk("b_wr_en", b_wr_en, cyc >= 5);
            if (cyc <= NB) chk("b_op_addr", b_op_addr, cyc - 1);
            if (cyc >= 2 && cyc <= NB + 1) chk("b_t_rd_addr", b_t_rd_addr, cyc - 2);
            if (cyc == 3) chk("b_cin_j0", b_if.carry_in, 0);
            if (b_wr_en) begin
                chk("b_wr_vs_rd", b_wr_addr != b_t_rd_addr, 1);
                chk("b_sb_nonempty", b_exp_q.size() != 0, 1);
                if (b_exp_q.size() != 0)
                    chk("b_wr", {8'(b_wr_addr), b_wr_data}, b_exp_q.pop_front());
            end
            if (cyc == NB + 4) chk("b_t_top", b_top, b_top_exp);
            if (cyc == abort_at) begin
                rst = 1'b1;
                b_exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        chk("b_busy_after", b_busy, 0);
        chk("b_sb_empty", b_exp_q.size(), 0);
    endtask

    task automatic b_rand_ops();
        for (int j = 0; j < NB; j++) begin
            b_oa0[j] = $urandom_range(32'hFFFF_FFFF, 0);
            b_oa1[j] = $urandom_range(32'hFFFF_FFFF, 0);
            b_m[j]   = $urandom_range(32'hFFFF_FFFF, 0);
        end
        b_ob0 = $urandom_range(32'hFFFF_FFFF, 0);
        b_ob1 = $urandom_range(32'hFFFF_FFFF, 0);
        b_mm  = $urandom_range(32'hFFFF_FFFF, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        s_start = 1'b0; s_ob0 = '0; s_ob1 = '0; s_mm = '0;
        s_ld_en = 1'b0; s_ld_addr = '0; s_ld_data = '0;
        b_start = 1'b0; b_ob0 = '0; b_ob1 = '0; b_mm = '0;
        b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        b_top_exp = '0;
        for (int j = 0; j < NS; j++) begin
            s_oa0[j] = '0; s_oa1[j] = '0; s_m[j] = '0;
        end
        for (int j = 0; j < NB; j++) begin
            b_oa0[j] = '0; b_oa1[j] = '0; b_m[j] = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Hand-worked vector: single product oa0*ob0 over zero t.
        s_oa0[0] = 8'hFF; s_oa0[1] = 8'hFF; s_ob0 = 8'hFF;
        s_load(0, 8'h00);
        s_load(1, 8'h00);
        s_iter(16'h00FF, 16'h01FE, 2'b00, 10'h0FE);

        // All-ones vector: carries 0x2FB then 0x2FD, top bits 2'b10.
        for (int j = 0; j < NS; j++) begin
            s_oa0[j] = 8'hFF; s_oa1[j] = 8'hFF; s_m[j] = 8'hFF;
        end
        s_ob0 = 8'hFF; s_ob1 = 8'hFF; s_mm = 8'hFF;
        s_load(0, 8'hFF);
        s_load(1, 8'hFF);
        s_iter(16'h00FD, 16'h01FD, 2'b10, 10'h2FB);

        // Random N=8 iterations against the golden model; t carries over between iterations.
        for (int j = 0; j < NB; j++) b_load(j, $urandom_range(32'hFFFF_FFFF, 0));
        b_rand_ops();
        b_iter(1'b0, 0);
        b_rand_ops();
        b_iter(1'b0, 0);

        // All-ones operands and t drive the carry into its top bits.
        for (int j = 0; j < NB; j++) begin
            b_oa0[j] = '1; b_oa1[j] = '1; b_m[j] = '1;
            b_load(j, '1);
        end
        b_ob0 = '1; b_ob1 = '1; b_mm = '1;
        b_iter(1'b0, 0);

        // start held high: iterations run back-to-back, none accepted while busy.
        for (int k = 0; k < 3; k++) begin
            b_rand_ops();
            b_iter(k < 2, 0);
        end

        // Reset in cycle 5 of a run, then a clean run.
        b_rand_ops();
        b_iter(1'b0, 5);
        @(negedge clk);
        chk_reset("abort");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_wr_en", b_wr_en, 0);
            chk("abort_idle_busy", b_busy, 0);
        end
        b_rand_ops();
        b_iter(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
